fib_seq: RTL and testbench
==========================

FIB_SEQ -- requirements
Module: fib_seq

Interface
REQ-001 Parameter WIDTH, default 32, data width of operands and result.
REQ-002 Parameter CNT_W, default 8, width of step-count input n.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request to begin a run, sampled on the rising edge.
REQ-007 a  input  WIDTH  seed term x0, captured on accepted start.
REQ-008 b  input  WIDTH  seed term y0, captured on accepted start.
REQ-009 n  input  CNT_W  number of addition steps, captured on accepted start.
REQ-010 out  output  WIDTH  registered result of last completed run.
REQ-011 busy  output  1  high while a run is in progress (state RUN).
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 overflow  output  1  sticky carry-out flag for the current or last run.

Function
REQ-014 The block SHALL implement states IDLE, RUN, DONE, held in a registered state variable.
REQ-015 In IDLE with start=1: capture x<=a, y<=b, cnt<=n, clear overflow, go to RUN.
REQ-016 Start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change mid-run.
REQ-017 In RUN with cnt!=0: one step per clock, x<=y, y<=(x+y) mod 2^WIDTH, cnt<=cnt-1.
REQ-018 In RUN with cnt==0: no step; out<=y; go to DONE.
REQ-019 In DONE: done=1 for exactly that cycle; go to IDLE on the next edge unconditionally.
REQ-020 Latency: done SHALL be high in the cycle following edge k+n+1, where k is the edge that accepted start (n=0 gives k+1).
REQ-021 Result SHALL equal the n-th term after seeds: n=1 gives a+b, n=2 gives b+(a+b), n=4 gives the fourth chained sum.
REQ-022 Addition SHALL be unsigned, wrapping modulo 2^WIDTH; no saturation.
REQ-023 overflow SHALL be set on any step whose WIDTH+1-bit sum has bit WIDTH = 1, and SHALL remain set until the next accepted start or reset.
REQ-024 out and overflow SHALL hold their values in IDLE until the next run completes or clears them.
REQ-025 busy = (state==RUN); done = (state==DONE); both SHALL be glitch-free registered decodes.
REQ-026 n = 2^CNT_W-1 SHALL complete correctly with no counter wrap.
REQ-027 The block SHALL be back-to-back capable: start asserted in the cycle done is high is ignored; start in the following IDLE cycle is accepted.

Reset
REQ-028 reset=1 SHALL, on the next edge, force state IDLE, out=0, busy=0, done=0, overflow=0, x=y=cnt=0.
REQ-029 reset SHALL take priority over start and over any in-progress run; an aborted run SHALL NOT assert done or update out.
REQ-030 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-031 WIDTH=32, a=1, b=1, n=4, start one cycle -> busy high 5 cycles, done pulse once, out=8, overflow=0.
REQ-032 a=5, b=7, n=0 -> done one edge after RUN entry, out=7, overflow=0.
REQ-033 a=0, b=1, n=46 -> out=2971215073 (0xB11924E1), overflow=0; rerun with n=47 -> out=512559680, overflow=1.
REQ-034 a=3, b=4, n=10, start held high for whole run and re-pulsed mid-run -> exactly one done, out computed from a=3, b=4 only, then a new run starts in the first IDLE cycle with start high.
REQ-035 Start run a=1, b=1, n=20, assert reset at step 5 -> out=0, busy=0, no done pulse; then a=2, b=3, n=1 -> out=5.
REQ-036 Overflow run followed by a=1, b=1, n=1 -> overflow clears on accept, out=2, overflow=0.

Source files
------------

// File: rtl/fib_seq.sv
// fib_seq: iterative Fibonacci-style sequencer.
// Seeds x0=a, y0=b are captured on an accepted start. The block then performs
// n wrapping additions (x,y) -> (y, x+y) and reports the final y on out.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   reset     synchronous active-high reset
//   start     run request, accepted only in IDLE
//   a, b      seed terms x0, y0 (WIDTH bits)
//   n         number of addition steps (CNT_W bits)
//   out       registered result of the last completed run
//   busy      high while a run is in progress
//   done      single-cycle completion pulse
//   overflow  sticky carry-out flag for the current or last run
module fib_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] n,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] out_d;
    logic             ovf_d;
    logic             busy_d;
    logic             done_d;
    logic [WIDTH:0]   sum_c;

    // One extra bit keeps the carry-out of each step visible.
    assign sum_c = {1'b0, x_q} + {1'b0, y_q};

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        out_d   = out;
        ovf_d   = overflow;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = a;
                    y_d     = b;
                    cnt_d   = n;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Zero test happens before decrement, so n = all-ones never wraps.
                if (cnt_q != '0) begin
                    x_d   = y_q;
                    y_d   = sum_c[WIDTH-1:0];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (sum_c[WIDTH]) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    out_d   = y_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they land in flops
        // aligned with the state register.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            out      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            out      <= out_d;
            overflow <= ovf_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_fib_seq.sv
// Testbench for fib_seq: directed scenarios plus randomized runs checked
// against a plain-arithmetic sequence model.
module tb_fib_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CNT_W-1:0] n;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;

    fib_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .n        (n),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the sequence with 64-bit arithmetic, record any carry.
    function automatic logic [32:0] ref_fib(input logic [31:0] s0, input logic [31:0] s1,
                                            input int steps);
        longint unsigned p;
        longint unsigned q;
        longint unsigned t;
        bit              ov;
        p  = longint'(s0);
        q  = longint'(s1);
        ov = 1'b0;
        for (int i = 0; i < steps; i++) begin
            t = p + q;
            if (t >= 64'h1_0000_0000) ov = 1'b1;
            p = q;
            q = t % 64'h1_0000_0000;
        end
        return {ov, q[31:0]};
    endfunction

    // Called at a falling edge in IDLE; returns at the falling edge after the accept edge.
    task automatic start_run(input logic [31:0] ra, input logic [31:0] rb, input logic [7:0] rn);
        a     = ra;
        b     = rb;
        n     = rn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        n     = 8'($urandom);
    endtask

    // Called at the falling edge after the accept edge (plus 'pre' cycles already
    // stepped and checked busy by the caller). Returns one cycle after done.
    task automatic wait_done(input string tag, input int steps, input logic [31:0] exp_out,
                             input bit exp_ovf, input int pre);
        int edges;
        int busy_cyc;
        edges    = pre;
        busy_cyc = pre;
        while (!done && edges < steps + 10) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'(steps + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(steps + 1));
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_out"}, 64'(out), 64'(exp_out));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done), 64'(0));
        check({tag, "_busy_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [32:0]      r;
        logic [31:0]      ra;
        logic [31:0]      rb;
        logic [7:0]       rn;
        int               done_seen;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        n     = '0;
        repeat (2) @(negedge clk);
        check("rst_out", 64'(out), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Small chain, zero steps, and the 32-bit overflow boundary.
        start_run(32'd1, 32'd1, 8'd4);
        wait_done("fib_1_1_4", 4, 32'd8, 1'b0, 0);
        start_run(32'd5, 32'd7, 8'd0);
        wait_done("n_zero", 0, 32'd7, 1'b0, 0);
        start_run(32'd0, 32'd1, 8'd46);
        wait_done("n46", 46, 32'hB11924E1, 1'b0, 0);
        start_run(32'd0, 32'd1, 8'd47);
        wait_done("n47", 47, 32'd512559680, 1'b1, 0);

        // Results must hold through idle cycles.
        repeat (3) @(negedge clk);
        check("idle_hold_out", 64'(out), 64'(512559680));
        check("idle_hold_ovf", 64'(overflow), 64'(1));

        // Overflow clears on the accept edge of the next run.
        start_run(32'd1, 32'd1, 8'd1);
        check("ovf_clear_on_accept", 64'(overflow), 64'(0));
        wait_done("after_ovf", 1, 32'd2, 1'b0, 0);

        // Start held and re-pulsed mid-run, operands disturbed mid-run.
        a     = 32'd3;
        b     = 32'd4;
        n     = 8'd10;
        start = 1'b1;
        @(negedge clk);
        a = 32'd2;
        b = 32'd3;
        n = 8'd2;
        for (int i = 0; i < 4; i++) begin
            check("hold_busy", 64'(busy), 64'(1));
            start = (i != 1);
            @(negedge clk);
        end
        r = ref_fib(32'd3, 32'd4, 10);
        wait_done("hold_run", 10, r[31:0], r[32], 4);
        // Start still high in the first IDLE cycle: a new run must begin.
        @(negedge clk);
        check("b2b_accept", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done("b2b_run", 2, 32'd8, 1'b0, 0);

        // Reset aborts a run: no done pulse, out cleared.
        start_run(32'd1, 32'd1, 8'd20);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out", 64'(out), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_ovf", 64'(overflow), 64'(0));
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) done_seen++;
            @(negedge clk);
        end
        check("abort_no_activity", 64'(done_seen), 64'(0));
        start_run(32'd2, 32'd3, 8'd1);
        wait_done("post_reset", 1, 32'd5, 1'b0, 0);

        // Maximum step count must not wrap the counter.
        ra = $urandom;
        rb = $urandom;
        r  = ref_fib(ra, rb, 255);
        start_run(ra, rb, 8'd255);
        wait_done("n_max", 255, r[31:0], r[32], 0);

        // Randomized runs against the model.
        for (int t = 0; t < 25; t++) begin
            ra = (t % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb = (t % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rn = 8'($urandom_range(0, 50));
            r  = ref_fib(ra, rb, int'(rn));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_run(ra, rb, rn);
            wait_done("rand", int'(rn), r[31:0], r[32], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
